control_unit: RTL and testbench
===============================

# control_unit

Hardwired multicycle controller for the 8-bit accumulator CPU. It consumes `opcode` and `ACisZero` from the datapath and drives every datapath enable and mux select, sequencing fetch, address-operand fetch and execute. It sits directly upstream of the datapath, and the two blocks together form the CPU core.

## Interface
Parameters: none. All opcode and state constants come from the shared package.

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high
- `opcode`  in  8  instruction register contents
- `ACisZero`  in  1  zero flag
- `writeEnableAC`, `writeEnableR`, `writeEnableMem`  out  1 each  AC / R / memory write
- `PCEnable`, `instructionRegisterEnable`  out  1 each  PC load / IR load
- `MSBaddressEnable`, `LSBaddressEnable`  out  1 each  address-byte register loads
- `zeroEnable`  out  1  zero-flag register load
- `muxSelectPC`  out  1  0 = PC+1, 1 = {MSB,LSB}
- `muxSelectAddress`  out  1  0 = PC, 1 = {MSB,LSB}
- `muxSelectALUtoAC`  out  1  0 = ALU result, 1 = MEM/R path
- `muxSelectMEM_or_R_toAC`  out  1  0 = R, 1 = MEM
- `instructionDone`  out  1  one-cycle pulse in the EXEC cycle

## Operation
- States: FETCH, ADDR_HI, ADDR_LO, EXEC. The state register is 2 bits and is the only storage.
- FETCH: memory address = PC. Assert `instructionRegisterEnable` and `PCEnable` (PC+1). Next state is ADDR_HI if the fetched opcode is a Γ instruction, otherwise EXEC.
  - Classification uses `opcode` in the following cycle, so FETCH always goes to a DECIDE-free path: the next state is ADDR_HI or EXEC, chosen from `opcode` at the start of that next cycle.
  - Implementation: FETCH → ADDR_HI unconditionally. ADDR_HI falls through to EXEC without enables when the opcode is non-Γ.
- ADDR_HI (Γ): memory address = PC. Assert `MSBaddressEnable` and `PCEnable`. Next state is ADDR_LO.
- ADDR_HI (non-Γ): all enables are 0. Next state is EXEC.
- ADDR_LO: memory address = PC. Assert `LSBaddressEnable` and `PCEnable`. Next state is EXEC.
- Γ operand encoding: high byte is at the opcode address + 1, low byte at + 2.
- EXEC actions, by opcode (next state is always FETCH; `instructionDone` = 1):
  - 0x00 NOP: no enables.
  - 0x01 LDAC: address sel 1, ALUtoAC 1, MEM_or_R 1, AC + zero enables.
  - 0x02 STAC: address sel 1, `writeEnableMem`.
  - 0x03 MVAC: `writeEnableR` only. The zero flag is not updated.
  - 0x04 MOVR: ALUtoAC 1, MEM_or_R 0, AC + zero enables.
  - 0x05 JUMP: `muxSelectPC` 1, `PCEnable`.
  - 0x06 JMPZ: JUMP action iff `ACisZero` = 1.
  - 0x07 JPNZ: JUMP action iff `ACisZero` = 0.
  - 0x08–0x0F (ALU): ALUtoAC 0, AC + zero enables. The ALU op is taken from `opcode[2:0]` inside the datapath.
  - Any other opcode: executes as NOP.
- Outputs not listed for a state are 0.
- Outputs are combinational from the state, `opcode` and `ACisZero`.

## Timing
- Reset:
  - While `reset` = 1, every output is forced to 0, including `instructionDone`.
  - State ← FETCH at the clock edge.
  - Reset asserted in any state, mid-instruction, aborts the instruction. The next post-reset cycle is FETCH.
- Cycle counts:
  - Non-Γ instructions: 3 cycles (FETCH, ADDR_HI pass-through, EXEC).
  - Γ instructions: 4 cycles.
  - Taken and untaken jumps cost the same. An untaken jump leaves PC = opcode address + 3.
- `ACisZero` is sampled combinationally during EXEC only.
- Memory read is asynchronous and write is synchronous. The controller relies on `readDataMEM` settling within the cycle in which the address mux is driven.

## Structure
- Package `cpu_pkg` holds:
  - `state_t` enum (FETCH, ADDR_HI, ADDR_LO, EXEC)
  - opcode localparams (`OP_NOP` … `OP_JPNZ`, `OP_ALU_BASE` = 8'h08)
  - function `is_gamma(opcode)`, true for 0x01, 0x02, 0x05, 0x06, 0x07
- One sub-module, `instr_decode`: combinational opcode → one-hot class (nop/ldac/stac/mvac/movr/jump/jmpz/jpnz/alu/gamma).
- `control_unit` contains the state register plus the output-decode always_comb.

## Test plan
- Reset held 2 cycles: all outputs 0 throughout. First cycle after release: `instructionRegisterEnable` = 1, `PCEnable` = 1, both address/PC selects 0.
- `opcode` = 0x08 (ADD): the ADDR_HI cycle has no enables. The next cycle has `writeEnableAC` = 1, `zeroEnable` = 1, ALUtoAC = 0, `instructionDone` = 1. FETCH follows.
- `opcode` = 0x01 (LDAC) with operand bytes 0x12, 0x34: MSB enable, then LSB enable, each with `PCEnable`. EXEC then has address sel 1, ALUtoAC 1, MEM_or_R 1, AC + zero enables.
- `opcode` = 0x06 (JMPZ): with `ACisZero` = 1, EXEC has `PCEnable` = 1 and `muxSelectPC` = 1. With `ACisZero` = 0, EXEC has `PCEnable` = 0. Both cases take 4 cycles.
- `opcode` = 0x02 (STAC): EXEC has `writeEnableMem` = 1, address sel 1, `writeEnableAC` = 0. `opcode` = 0x03: only `writeEnableR`, with `zeroEnable` = 0.
- `reset` pulsed during ADDR_LO: the pulse cycle has no enables and the next cycle is FETCH. `opcode` = 0x20 completes as a NOP in 3 cycles with no write enables.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared constants for the 8-bit accumulator CPU: FSM states, opcodes,
// and the decoded instruction-class record.
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        ADDR_HI = 2'd1,
        ADDR_LO = 2'd2,
        EXEC    = 2'd3
    } state_t;

    localparam logic [7:0] OP_NOP      = 8'h00;
    localparam logic [7:0] OP_LDAC     = 8'h01;
    localparam logic [7:0] OP_STAC     = 8'h02;
    localparam logic [7:0] OP_MVAC     = 8'h03;
    localparam logic [7:0] OP_MOVR     = 8'h04;
    localparam logic [7:0] OP_JUMP     = 8'h05;
    localparam logic [7:0] OP_JMPZ     = 8'h06;
    localparam logic [7:0] OP_JPNZ     = 8'h07;
    localparam logic [7:0] OP_ALU_BASE = 8'h08;

    // Exactly one of nop..alu is set; gamma flags a two-byte address operand.
    typedef struct packed {
        logic nop;
        logic ldac;
        logic stac;
        logic mvac;
        logic movr;
        logic jump;
        logic jmpz;
        logic jpnz;
        logic alu;
        logic gamma;
    } op_class_t;

    function automatic logic is_gamma(input logic [7:0] opcode);
        return (opcode == OP_LDAC) || (opcode == OP_STAC) || (opcode == OP_JUMP) ||
               (opcode == OP_JMPZ) || (opcode == OP_JPNZ);
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Controller <-> datapath bundle: opcode/zero flag in, enables and selects out.
interface control_unit_if;
    logic [7:0] opcode;
    logic       ACisZero;
    logic       writeEnableAC;
    logic       writeEnableR;
    logic       writeEnableMem;
    logic       PCEnable;
    logic       instructionRegisterEnable;
    logic       MSBaddressEnable;
    logic       LSBaddressEnable;
    logic       zeroEnable;
    logic       muxSelectPC;
    logic       muxSelectAddress;
    logic       muxSelectALUtoAC;
    logic       muxSelectMEM_or_R_toAC;
    logic       instructionDone;

    modport master (
        input  opcode, ACisZero,
        output writeEnableAC, writeEnableR, writeEnableMem, PCEnable,
               instructionRegisterEnable, MSBaddressEnable, LSBaddressEnable,
               zeroEnable, muxSelectPC, muxSelectAddress, muxSelectALUtoAC,
               muxSelectMEM_or_R_toAC, instructionDone
    );

    modport slave (
        output opcode, ACisZero,
        input  writeEnableAC, writeEnableR, writeEnableMem, PCEnable,
               instructionRegisterEnable, MSBaddressEnable, LSBaddressEnable,
               zeroEnable, muxSelectPC, muxSelectAddress, muxSelectALUtoAC,
               muxSelectMEM_or_R_toAC, instructionDone
    );
endinterface

// File: rtl/control_unit_instr_decode.sv
// Combinational opcode classifier; anything outside the defined set decodes as NOP.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [7:0] opcode_i,
    output op_class_t  class_o
);

    always_comb begin
        class_o = '0;
        case (opcode_i)
            OP_NOP:  class_o.nop  = 1'b1;
            OP_LDAC: class_o.ldac = 1'b1;
            OP_STAC: class_o.stac = 1'b1;
            OP_MVAC: class_o.mvac = 1'b1;
            OP_MOVR: class_o.movr = 1'b1;
            OP_JUMP: class_o.jump = 1'b1;
            OP_JMPZ: class_o.jmpz = 1'b1;
            OP_JPNZ: class_o.jpnz = 1'b1;
            default: begin
                // 0x08-0x0F share the ALU path; the datapath picks the op from opcode[2:0]
                if (opcode_i[7:3] == OP_ALU_BASE[7:3]) class_o.alu = 1'b1;
                else                                   class_o.nop = 1'b1;
            end
        endcase
        class_o.gamma = is_gamma(opcode_i);
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired multicycle controller: FETCH -> ADDR_HI -> [ADDR_LO] -> EXEC.
// The 2-bit state is the only storage; all outputs decode combinationally.
module control_unit
    import cpu_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    control_unit_if.master cu
);

    state_t    state_q, state_d;
    op_class_t cls;
    logic      jump_taken;

    instr_decode u_decode (
        .opcode_i (cu.opcode),
        .class_o  (cls)
    );

    assign jump_taken = cls.jump | (cls.jmpz & cu.ACisZero) | (cls.jpnz & ~cu.ACisZero);

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // The IR only holds the new opcode after FETCH, so classification waits until ADDR_HI.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   state_d = ADDR_HI;
            ADDR_HI: state_d = cls.gamma ? ADDR_LO : EXEC;
            ADDR_LO: state_d = EXEC;
            EXEC:    state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        cu.writeEnableAC             = 1'b0;
        cu.writeEnableR              = 1'b0;
        cu.writeEnableMem            = 1'b0;
        cu.PCEnable                  = 1'b0;
        cu.instructionRegisterEnable = 1'b0;
        cu.MSBaddressEnable          = 1'b0;
        cu.LSBaddressEnable          = 1'b0;
        cu.zeroEnable                = 1'b0;
        cu.muxSelectPC               = 1'b0;
        cu.muxSelectAddress          = 1'b0;
        cu.muxSelectALUtoAC          = 1'b0;
        cu.muxSelectMEM_or_R_toAC    = 1'b0;
        cu.instructionDone           = 1'b0;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    cu.instructionRegisterEnable = 1'b1;
                    cu.PCEnable                  = 1'b1;
                end
                ADDR_HI: begin
                    cu.MSBaddressEnable = cls.gamma;
                    cu.PCEnable         = cls.gamma;
                end
                ADDR_LO: begin
                    cu.LSBaddressEnable = 1'b1;
                    cu.PCEnable         = 1'b1;
                end
                EXEC: begin
                    cu.instructionDone = 1'b1;
                    case (1'b1)
                        cls.nop: ;
                        cls.ldac: begin
                            cu.muxSelectAddress       = 1'b1;
                            cu.muxSelectALUtoAC       = 1'b1;
                            cu.muxSelectMEM_or_R_toAC = 1'b1;
                            cu.writeEnableAC          = 1'b1;
                            cu.zeroEnable             = 1'b1;
                        end
                        cls.stac: begin
                            cu.muxSelectAddress = 1'b1;
                            cu.writeEnableMem   = 1'b1;
                        end
                        cls.mvac: cu.writeEnableR = 1'b1;
                        cls.movr: begin
                            cu.muxSelectALUtoAC = 1'b1;
                            cu.writeEnableAC    = 1'b1;
                            cu.zeroEnable       = 1'b1;
                        end
                        cls.jump, cls.jmpz, cls.jpnz: begin
                            cu.muxSelectPC = jump_taken;
                            cu.PCEnable    = jump_taken;
                        end
                        cls.alu: begin
                            cu.writeEnableAC = 1'b1;
                            cu.zeroEnable    = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: expected output vectors are queued as
// each cycle's inputs are driven and compared mid-cycle on the falling edge.
module tb_control_unit;

    localparam logic [12:0] B_AC    = 13'h1000;
    localparam logic [12:0] B_R     = 13'h0800;
    localparam logic [12:0] B_MEM   = 13'h0400;
    localparam logic [12:0] B_PC    = 13'h0200;
    localparam logic [12:0] B_IR    = 13'h0100;
    localparam logic [12:0] B_MSB   = 13'h0080;
    localparam logic [12:0] B_LSB   = 13'h0040;
    localparam logic [12:0] B_Z     = 13'h0020;
    localparam logic [12:0] B_SPC   = 13'h0010;
    localparam logic [12:0] B_SADDR = 13'h0008;
    localparam logic [12:0] B_A2AC  = 13'h0004;
    localparam logic [12:0] B_MR    = 13'h0002;
    localparam logic [12:0] B_DONE  = 13'h0001;

    localparam logic [12:0] V_FETCH = B_PC | B_IR;
    localparam logic [12:0] V_HI    = B_PC | B_MSB;
    localparam logic [12:0] V_LO    = B_PC | B_LSB;

    logic        clk;
    logic        reset;
    logic [12:0] outs;
    logic [12:0] sb[$];
    int          vectors;
    int          miscompares;

    control_unit_if cif ();

    control_unit dut (
        .clk   (clk),
        .reset (reset),
        .cu    (cif)
    );

    assign outs = {cif.writeEnableAC, cif.writeEnableR, cif.writeEnableMem, cif.PCEnable,
                   cif.instructionRegisterEnable, cif.MSBaddressEnable, cif.LSBaddressEnable,
                   cif.zeroEnable, cif.muxSelectPC, cif.muxSelectAddress, cif.muxSelectALUtoAC,
                   cif.muxSelectMEM_or_R_toAC, cif.instructionDone};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic gamma_op(input logic [7:0] op);
        return op inside {8'h01, 8'h02, 8'h05, 8'h06, 8'h07};
    endfunction

    function automatic logic [12:0] exec_vec(input logic [7:0] op, input logic z);
        logic [12:0] jmp;
        jmp = B_SPC | B_PC | B_DONE;
        case (op)
            8'h01: return B_SADDR | B_A2AC | B_MR | B_AC | B_Z | B_DONE;
            8'h02: return B_SADDR | B_MEM | B_DONE;
            8'h03: return B_R | B_DONE;
            8'h04: return B_A2AC | B_AC | B_Z | B_DONE;
            8'h05: return jmp;
            8'h06: return z ? jmp : B_DONE;
            8'h07: return z ? B_DONE : jmp;
            8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F: return B_AC | B_Z | B_DONE;
            default: return B_DONE;
        endcase
    endfunction

    task automatic drive(input logic r, input logic [7:0] op, input logic z);
        @(posedge clk);
        #1;
        reset        = r;
        cif.opcode   = op;
        cif.ACisZero = z;
    endtask

    task automatic test_reset();
        logic        r[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [12:0] w[5]  = '{13'h0, 13'h0, V_FETCH, 13'h0, B_DONE};
        logic [7:0]  op[5] = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00};
        logic [12:0] got, want;
        for (int c = 0; c < 5; c++) begin
            drive(r[c], op[c], 1'b1);
            sb.push_back(w[c]);
            @(negedge clk);
            got  = outs;
            want = sb.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL reset cyc%0d got=%h want=%h", c, got, want);
            end
        end
    endtask

    task automatic test_nongamma();
        logic [7:0]  ops[7] = '{8'h08, 8'h0D, 8'h0F, 8'h03, 8'h04, 8'h00, 8'h20};
        logic [7:0]  dop;
        logic        dz;
        logic [12:0] got, want;
        for (int k = 0; k < 7; k++) begin
            for (int c = 0; c < 3; c++) begin
                dz = 1'(k & 1);
                if (c == 0)      begin dop = 8'($urandom_range(0, 255)); want = V_FETCH; end
                else if (c == 1) begin dop = ops[k]; want = 13'h0; end
                else             begin dop = ops[k]; want = exec_vec(ops[k], dz); end
                drive(1'b0, dop, dz);
                sb.push_back(want);
                @(negedge clk);
                got  = outs;
                want = sb.pop_front();
                vectors++;
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL nongamma op=%h cyc%0d got=%h want=%h", ops[k], c, got, want);
                end
            end
        end
    endtask

    task automatic test_gamma();
        logic [7:0]  ops[8] = '{8'h01, 8'h02, 8'h05, 8'h06, 8'h06, 8'h07, 8'h07, 8'h05};
        logic        zs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0]  dop;
        logic        dz;
        logic [12:0] got, want;
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < 4; c++) begin
                dop = ops[k];
                dz  = ~zs[k];
                case (c)
                    0:       begin dop = 8'($urandom_range(0, 255)); want = V_FETCH; end
                    1:       want = V_HI;
                    2:       want = V_LO;
                    default: begin dz = zs[k]; want = exec_vec(ops[k], zs[k]); end
                endcase
                drive(1'b0, dop, dz);
                sb.push_back(want);
                @(negedge clk);
                got  = outs;
                want = sb.pop_front();
                vectors++;
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL gamma op=%h z=%0d cyc%0d got=%h want=%h", ops[k], zs[k], c, got, want);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic        r[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0]  op[6] = '{8'h44, 8'h01, 8'h01, 8'h20, 8'h20, 8'h20};
        logic [12:0] w[6]  = '{V_FETCH, V_HI, 13'h0, V_FETCH, 13'h0, B_DONE};
        logic [12:0] got, want;
        for (int c = 0; c < 6; c++) begin
            drive(r[c], op[c], 1'b1);
            sb.push_back(w[c]);
            @(negedge clk);
            got  = outs;
            want = sb.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL reset_mid cyc%0d got=%h want=%h", c, got, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  op, dop;
        logic        z, g;
        int          n;
        logic [12:0] got, want;
        for (int k = 0; k < 30; k++) begin
            op = (k % 7 == 6) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
            z  = 1'($urandom_range(0, 1));
            g  = gamma_op(op);
            n  = g ? 4 : 3;
            for (int c = 0; c < n; c++) begin
                dop = op;
                if (c == 0)          begin dop = 8'($urandom_range(0, 255)); want = V_FETCH; end
                else if (c == n - 1) want = exec_vec(op, z);
                else if (!g)         want = 13'h0;
                else                 want = (c == 1) ? V_HI : V_LO;
                drive(1'b0, dop, (c == n - 1) ? z : ~z);
                sb.push_back(want);
                @(negedge clk);
                got  = outs;
                want = sb.pop_front();
                vectors++;
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL b2b op=%h z=%0d cyc%0d got=%h want=%h", op, z, c, got, want);
                end
            end
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b1;
        cif.opcode   = 8'h00;
        cif.ACisZero = 1'b0;
        test_reset();
        test_nongamma();
        test_gamma();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
